// File: rtl/pico_io_bridge.sv
// pico_io_bridge
// I/O and interrupt bridge between the KCPSM6 port bus and fabric logic.
//   - OUTPUT / OUTPUTK writes land in N_OUT byte registers (out_regs).
//   - in_port is a registered mux of N_IN fabric bytes plus the interrupt
//     pending and mask registers.
//   - An N_IRQ-channel rising-edge interrupt controller with a mask,
//     write-1-to-clear pending register and an interrupt/interrupt_ack
//     handshake.
//
// Ports:
//   clk            system clock, rising edge
//   cpu_reset_n    asynchronous active-low reset
//   port_id        KCPSM6 port address
//   out_port       KCPSM6 write data
//   write_strobe   OUTPUT strobe
//   k_write_strobe OUTPUTK strobe (decodes port_id[3:0] only)
//   read_strobe    INPUT strobe (no side effects)
//   in_port        registered read data to KCPSM6
//   interrupt      interrupt request to KCPSM6 (registered)
//   interrupt_ack  interrupt acknowledge from KCPSM6
//   out_regs       output register bank, byte i at [8i+7:8i]
//   in_data        fabric input bytes, byte i at [8i+7:8i]
//   irq_src        interrupt sources, rising-edge sensitive
//
// Optional build macro PICO_IO_SYNC_EN: when defined, in_data and irq_src
// pass through 2-flop synchronisers before use (read latency 3 cycles,
// interrupt latency 5 cycles). When undefined, inputs are used directly.

module pico_io_bridge #(
   parameter int unsigned N_OUT         = 4,
   parameter int unsigned N_IN          = 4,
   parameter int unsigned N_IRQ         = 4,
   parameter logic [7:0]  BASE_OUT      = 8'h00,
   parameter logic [7:0]  BASE_IN       = 8'h00,
   parameter logic [7:0]  IRQ_STATUS_ID = 8'hF0,
   parameter logic [7:0]  IRQ_MASK_ID   = 8'hF1,
   parameter logic [7:0]  MASK_RST      = 8'h00
) (
   input  logic                 clk,
   input  logic                 cpu_reset_n,
   input  logic [7:0]           port_id,
   input  logic [7:0]           out_port,
   input  logic                 write_strobe,
   input  logic                 k_write_strobe,
   input  logic                 read_strobe,
   output logic [7:0]           in_port,
   output logic                 interrupt,
   input  logic                 interrupt_ack,
   output logic [8*N_OUT-1:0]   out_regs,
   input  logic [8*N_IN-1:0]    in_data,
   input  logic [N_IRQ-1:0]     irq_src
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ASSERT  = 2'd1,
      ST_SERVICE = 2'd2
   } irq_state_t;

   // Address windows widened to 9 bits so BASE+N never wraps past 8'hFF.
   localparam logic [8:0] OUT_LO = {1'b0, BASE_OUT};
   localparam logic [8:0] OUT_HI = OUT_LO + 9'(N_OUT);
   localparam logic [8:0] IN_LO  = {1'b0, BASE_IN};
   localparam logic [8:0] IN_HI  = IN_LO + 9'(N_IN);

   logic [8*N_IN-1:0]       in_data_s;
   logic [N_IRQ-1:0]        irq_s;

   logic [N_OUT-1:0][7:0]   out_q;
   logic [N_IRQ-1:0]        hist;
   logic [N_IRQ-1:0]        pending;
   logic [N_IRQ-1:0]        mask;
   irq_state_t              state;

   logic                    status_hit;
   logic                    mask_hit;
   logic                    out_hit;
   logic                    in_hit;
   logic                    k_hit;
   logic [3:0]              out_idx;
   logic [3:0]              in_idx;
   logic [N_OUT-1:0]        out_we;
   logic [7:0]              rd_data;
   logic                    status_wr;
   logic [N_IRQ-1:0]        w1c;
   logic [N_IRQ-1:0]        rise;

   // ------------------------------------------------------------------
   // Optional input synchronisers
   // ------------------------------------------------------------------
`ifdef PICO_IO_SYNC_EN
   logic [8*N_IN-1:0] in_meta, in_sync;
   logic [N_IRQ-1:0]  irq_meta, irq_sync;

   // irq stages reset high so a source held high at reset release is not
   // seen as a rising edge.
   always_ff @(posedge clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         in_meta  <= '0;
         in_sync  <= '0;
         irq_meta <= '1;
         irq_sync <= '1;
      end else begin
         in_meta  <= in_data;
         in_sync  <= in_meta;
         irq_meta <= irq_src;
         irq_sync <= irq_meta;
      end
   end

   assign in_data_s = in_sync;
   assign irq_s     = irq_sync;
`else
   assign in_data_s = in_data;
   assign irq_s     = irq_src;
`endif

   // ------------------------------------------------------------------
   // Address decode
   // ------------------------------------------------------------------
   assign status_hit = (port_id == IRQ_STATUS_ID);
   assign mask_hit   = (port_id == IRQ_MASK_ID);
   // The interrupt registers shadow any overlapping out/in address.
   assign out_hit    = !status_hit && !mask_hit &&
                       ({1'b0, port_id} >= OUT_LO) && ({1'b0, port_id} < OUT_HI);
   assign in_hit     = !status_hit && !mask_hit &&
                       ({1'b0, port_id} >= IN_LO) && ({1'b0, port_id} < IN_HI);
   assign out_idx    = 4'(port_id - BASE_OUT);
   assign in_idx     = 4'(port_id - BASE_IN);
   // OUTPUTK carries only a 4-bit constant port address.
   assign k_hit      = ({1'b0, port_id[3:0]} < 5'(N_OUT));

   assign status_wr  = write_strobe && status_hit;
   assign w1c        = status_wr ? out_port[N_IRQ-1:0] : '0;
   assign rise       = irq_s & ~hist;

   // NOTE: every signal driven in always_comb gets a default first so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      out_we = '0;
      for (int i = 0; i < N_OUT; i++) begin
         if (k_write_strobe && k_hit && (port_id[3:0] == 4'(i)))
            out_we[i] = 1'b1;
         if (write_strobe && out_hit && (out_idx == 4'(i)))
            out_we[i] = 1'b1;
      end
   end

   always_comb begin
      rd_data = '0;
      if (status_hit) begin
         rd_data[N_IRQ-1:0] = pending;
      end else if (mask_hit) begin
         rd_data[N_IRQ-1:0] = mask;
      end else if (in_hit) begin
         for (int i = 0; i < N_IN; i++) begin
            if (in_idx == 4'(i))
               rd_data = in_data_s[8*i +: 8];
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers: output bank, read path, interrupt status
   // ------------------------------------------------------------------
   // NOTE: the output bank is a handful of flops, not a RAM, so it takes
   // the async reset like every other register here; a true memory would
   // be left unreset.
   always_ff @(posedge clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         out_q   <= '0;
         in_port <= '0;
         hist    <= '1;
         pending <= '0;
         mask    <= MASK_RST[N_IRQ-1:0];
      end else begin
         // NOTE: non-blocking assignments keep every flop sampling the
         // pre-edge values, independent of statement order.
         for (int i = 0; i < N_OUT; i++) begin
            if (out_we[i])
               out_q[i] <= out_port;
         end
         // Read data is sampled every cycle; read_strobe has no effect.
         in_port <= rd_data;
         hist    <= irq_s;
         // A new edge beats a simultaneous write-1-to-clear.
         pending <= rise | (pending & ~w1c);
         if (write_strobe && mask_hit)
            mask <= out_port[N_IRQ-1:0];
      end
   end

   assign out_regs = out_q;

   // ------------------------------------------------------------------
   // Interrupt handshake FSM with registered interrupt output
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge cpu_reset_n) begin
      if (!cpu_reset_n) begin
         state     <= ST_IDLE;
         interrupt <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               interrupt <= 1'b0;
               if (|(pending & mask))
                  state <= ST_ASSERT;
            end
            ST_ASSERT: begin
               if (interrupt_ack) begin
                  state     <= ST_SERVICE;
                  interrupt <= 1'b0;
               end else begin
                  interrupt <= 1'b1;
               end
            end
            ST_SERVICE: begin
               interrupt <= 1'b0;
               // Any status write ends service; IDLE then re-checks what
               // is still pending and enabled.
               if (status_wr)
                  state <= ST_IDLE;
            end
            default: begin
               state     <= ST_IDLE;
               interrupt <= 1'b0;
            end
         endcase
      end
   end

   // read_strobe is part of the port bus but has no side effects here.
   logic unused_ok;
   assign unused_ok = read_strobe;

endmodule

// File: tb/tb_pico_io_bridge.sv
// tb_pico_io_bridge
// Directed self-checking bench for pico_io_bridge with default parameters
// (N_OUT=4, N_IN=4, N_IRQ=4, BASE_OUT=BASE_IN=8'h00, status 8'hF0,
// mask 8'hF1, MASK_RST=8'h00). Inputs change and outputs are sampled on
// the falling clock edge.

module tb_pico_io_bridge;

   logic        clk = 1'b0;
   logic        cpu_reset_n;
   logic [7:0]  port_id;
   logic [7:0]  out_port;
   logic        write_strobe;
   logic        k_write_strobe;
   logic        read_strobe;
   logic [7:0]  in_port;
   logic        interrupt;
   logic        interrupt_ack;
   logic [31:0] out_regs;
   logic [31:0] in_data;
   logic [3:0]  irq_src;

   int n_tests = 0;
   int n_fail  = 0;

   pico_io_bridge dut (
      .clk            (clk),
      .cpu_reset_n    (cpu_reset_n),
      .port_id        (port_id),
      .out_port       (out_port),
      .write_strobe   (write_strobe),
      .k_write_strobe (k_write_strobe),
      .read_strobe    (read_strobe),
      .in_port        (in_port),
      .interrupt      (interrupt),
      .interrupt_ack  (interrupt_ack),
      .out_regs       (out_regs),
      .in_data        (in_data),
      .irq_src        (irq_src)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One-cycle OUTPUT (k=0) or OUTPUTK (k=1) write; returns on the falling
   // edge after the write edge, so the result is already visible.
   task automatic wr(input logic [7:0] id, input logic [7:0] d, input bit k);
      @(negedge clk);
      port_id  = id;
      out_port = d;
      if (k) k_write_strobe = 1'b1;
      else   write_strobe   = 1'b1;
      @(negedge clk);
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
   endtask

   // Present port_id, then check in_port one clock later.
   task automatic rd_check(input string tag, input logic [7:0] id, input logic [7:0] exp);
      @(negedge clk);
      port_id     = id;
      read_strobe = 1'b1;
      @(negedge clk);
      read_strobe = 1'b0;
      check(tag, {24'h0, in_port}, {24'h0, exp});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      cpu_reset_n    = 1'b0;
      port_id        = 8'h00;
      out_port       = 8'h00;
      write_strobe   = 1'b0;
      k_write_strobe = 1'b0;
      read_strobe    = 1'b0;
      interrupt_ack  = 1'b0;
      in_data        = 32'h0;
      irq_src        = 4'h0;

      // ---------------- reset state ----------------
      #12;
      check("rst_out_regs",  out_regs, 32'h0);
      check("rst_in_port",   {24'h0, in_port}, 32'h0);
      check("rst_interrupt", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      cpu_reset_n = 1'b1;
      rd_check("rst_mask", 8'hF1, 8'h00);
      rd_check("rst_pending", 8'hF0, 8'h00);

      // ---------------- OUTPUT writes ----------------
      wr(8'h02, 8'hA5, 1'b0);
      check("wr_byte2", out_regs, 32'h00A5_0000);
      wr(8'h07, 8'hFF, 1'b0);
      check("wr_unmapped", out_regs, 32'h00A5_0000);
      wr(8'h03, 8'h11, 1'b0);
      check("wr_last_byte", out_regs, 32'h11A5_0000);
      wr(8'h04, 8'h77, 1'b0);
      check("wr_just_past", out_regs, 32'h11A5_0000);

      // ---------------- OUTPUTK writes ----------------
      wr(8'h31, 8'h3C, 1'b1);
      check("wrk_byte1", out_regs, 32'h11A5_3C00);
      wr(8'h39, 8'hEE, 1'b1);
      check("wrk_ignored", out_regs, 32'h11A5_3C00);

      // ---------------- read path ----------------
      in_data = 32'h5A33_2211;
      rd_check("rd_byte3", 8'h03, 8'h5A);
      @(negedge clk);
      port_id = 8'h00;
      #1;
      check("rd_latency_hold", {24'h0, in_port}, 32'h5A);
      @(negedge clk);
      check("rd_byte0", {24'h0, in_port}, 32'h11);
      rd_check("rd_unmapped", 8'h04, 8'h00);
      wr(8'hF1, 8'h05, 1'b0);
      rd_check("rd_mask", 8'hF1, 8'h05);

      // ---------------- IRQ handshake ----------------
      wr(8'hF1, 8'h01, 1'b0);
      port_id = 8'h00;
      irq_src = 4'h1;
      @(negedge clk);
      irq_src = 4'h0;
      check("irq_lat1", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      check("irq_lat2", {31'h0, interrupt}, 32'h0);
      @(negedge clk);
      check("irq_lat3", {31'h0, interrupt}, 32'h1);
      rd_check("irq_pending", 8'hF0, 8'h01);
      check("irq_held", {31'h0, interrupt}, 32'h1);
      interrupt_ack = 1'b1;
      @(negedge clk);
      interrupt_ack = 1'b0;
      check("irq_ack_drop", {31'h0, interrupt}, 32'h0);
      cycles(3);
      check("irq_service_low", {31'h0, interrupt}, 32'h0);
      wr(8'hF0, 8'h01, 1'b0);
      cycles(3);
      check("irq_no_reassert", {31'h0, interrupt}, 32'h0);
      rd_check("irq_cleared", 8'hF0, 8'h00);

      // ---------------- masked source, set wins ----------------
      wr(8'hF1, 8'h00, 1'b0);
      irq_src = 4'h4;
      @(negedge clk);
      irq_src = 4'h0;
      cycles(3);
      check("mask_no_irq", {31'h0, interrupt}, 32'h0);
      rd_check("mask_pending", 8'hF0, 8'h04);
      @(negedge clk);
      port_id      = 8'hF0;
      out_port     = 8'h04;
      write_strobe = 1'b1;
      irq_src      = 4'h4;
      @(negedge clk);
      write_strobe = 1'b0;
      irq_src      = 4'h0;
      @(negedge clk);
      check("set_wins", {24'h0, in_port}, 32'h04);
      wr(8'hF0, 8'h04, 1'b0);
      rd_check("w1c_clears", 8'hF0, 8'h00);

      // ---------------- reset mid-ASSERT ----------------
      wr(8'hF1, 8'h01, 1'b0);
      irq_src = 4'h1;
      @(negedge clk);
      irq_src = 4'h0;
      port_id = 8'h03;
      cycles(2);
      check("pre_rst_irq", {31'h0, interrupt}, 32'h1);
      check("pre_rst_in_port", {24'h0, in_port}, 32'h5A);
      #2;
      cpu_reset_n = 1'b0;
      #1;
      check("arst_interrupt", {31'h0, interrupt}, 32'h0);
      check("arst_out_regs", out_regs, 32'h0);
      check("arst_in_port", {24'h0, in_port}, 32'h0);
      @(negedge clk);
      cpu_reset_n = 1'b1;
      rd_check("arst_pending", 8'hF0, 8'h00);
      rd_check("arst_mask", 8'hF1, 8'h00);

      // ---------------- source high across reset release ----------------
      @(negedge clk);
      cpu_reset_n = 1'b0;
      irq_src     = 4'h1;
      @(negedge clk);
      cpu_reset_n = 1'b1;
      wr(8'hF1, 8'h01, 1'b0);
      cycles(3);
      check("hist_no_fire", {31'h0, interrupt}, 32'h0);
      rd_check("hist_pending", 8'hF0, 8'h00);
      irq_src = 4'h0;
      cycles(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
